// File: rtl/fir_pkg.sv
// Shared constants and FSM encoding for the FIR coefficient-memory controller.
package fir_pkg;
    localparam int AW_DEF   = 6;
    localparam int DW_DEF   = 16;
    localparam int NTAP_DEF = 2 ** AW_DEF;

    typedef enum logic [2:0] {
        IDLE,
        SWEEP,
        DRAIN,
        HOST_WR,
        HOST_RD,
        HOST_RSP
    } state_t;
endpackage

// File: rtl/fir_cmem_ctrl.sv
// Arbitrates a single-port coefficient RAM between full-table sweeps feeding
// the FIR datapath and single-word host reads/writes.
module fir_cmem_ctrl
    import fir_pkg::*;
#(
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF,
    parameter int NTAP = NTAP_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sweep_start,
    output logic          sweep_busy,
    output logic          sweep_drop,
    output logic          coef_valid,
    output logic [AW-1:0] coef_idx,
    output logic [DW-1:0] coef_data,
    output logic          coef_last,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          cmem_cen,
    output logic          cmem_wen,
    output logic [AW-1:0] cmem_a,
    output logic [DW-1:0] cmem_d,
    input  logic [DW-1:0] cmem_q
);
    localparam logic [AW-1:0] LAST_IDX = AW'(NTAP - 1);

    state_t          r_state;
    logic            r_prio;
    logic            r_cen, r_wen;
    logic [AW-1:0]   r_a;
    logic [DW-1:0]   r_d;
    logic            r_ack, r_rvalid;
    logic [DW-1:0]   r_rdata;
    logic            r_cvalid, r_clast;
    logic [AW-1:0]   r_cidx;
    logic            w_accept_sweep;

    // A pending host request with priority beats a simultaneous sweep_start.
    assign w_accept_sweep = (r_state == IDLE) && sweep_start && !(host_req && r_prio);

    assign sweep_drop  = rst_n && sweep_start && !w_accept_sweep;
    assign sweep_busy  = (r_state == SWEEP) || (r_state == DRAIN);
    assign coef_valid  = r_cvalid;
    assign coef_idx    = r_cidx;
    assign coef_last   = r_clast;
    assign coef_data   = cmem_q;
    assign host_ack    = r_ack;
    assign host_rvalid = r_rvalid;
    // Read data is live from the RAM in the response cycle, then held.
    assign host_rdata  = (r_state == HOST_RSP) ? cmem_q : r_rdata;
    assign cmem_cen    = r_cen;
    assign cmem_wen    = r_wen;
    assign cmem_a      = r_a;
    assign cmem_d      = r_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_prio   <= 1'b0;
            r_cen    <= 1'b1;
            r_wen    <= 1'b1;
            r_a      <= '0;
            r_d      <= '0;
            r_ack    <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_cvalid <= 1'b0;
            r_clast  <= 1'b0;
            r_cidx   <= '0;
        end else begin
            r_cen    <= 1'b1;
            r_wen    <= 1'b1;
            r_a      <= '0;
            r_d      <= '0;
            r_ack    <= 1'b0;
            r_rvalid <= 1'b0;
            // Sweep data emerges one cycle after its read is issued.
            r_cvalid <= (r_state == SWEEP);
            r_clast  <= (r_state == SWEEP) && (r_a == LAST_IDX);
            r_cidx   <= r_a;
            case (r_state)
                IDLE: begin
                    if (w_accept_sweep) begin
                        r_state <= SWEEP;
                        r_cen   <= 1'b0;
                    end else if (host_req) begin
                        r_prio <= 1'b0;
                        r_cen  <= 1'b0;
                        r_a    <= host_addr;
                        if (host_we) begin
                            r_state <= HOST_WR;
                            r_wen   <= 1'b0;
                            r_d     <= host_wdata;
                            r_ack   <= 1'b1;
                        end else begin
                            r_state <= HOST_RD;
                        end
                    end
                end
                SWEEP: begin
                    if (r_a == LAST_IDX) begin
                        r_state <= DRAIN;
                        if (host_req) r_prio <= 1'b1;
                    end else begin
                        r_cen <= 1'b0;
                        r_a   <= r_a + 1'b1;
                    end
                end
                HOST_RD: begin
                    r_state  <= HOST_RSP;
                    r_ack    <= 1'b1;
                    r_rvalid <= 1'b1;
                end
                HOST_RSP: begin
                    r_state <= IDLE;
                    r_rdata <= cmem_q;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_cmem_ctrl.sv
// Scoreboard bench for fir_cmem_ctrl with a behavioral single-port RAM.
module tb_fir_cmem_ctrl;
    localparam int AW = 6;
    localparam int DW = 16;
    localparam int NTAP = 64;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
        logic          last;
    } coef_t;

    logic          clk = 1'b0;
    logic          rst_n, sweep_start, sweep_busy, sweep_drop;
    logic          coef_valid, coef_last;
    logic [AW-1:0] coef_idx;
    logic [DW-1:0] coef_data;
    logic          host_req, host_we, host_ack, host_rvalid;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata, host_rdata;
    logic          cmem_cen, cmem_wen;
    logic [AW-1:0] cmem_a;
    logic [DW-1:0] cmem_d, cmem_q;

    logic [DW-1:0] mem [NTAP];
    logic          preload;
    coef_t         coef_q[$];
    logic [DW-1:0] host_q[$];
    int            n_chk = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    fir_cmem_ctrl #(.AW(AW), .DW(DW), .NTAP(NTAP)) dut (
        .clk(clk), .rst_n(rst_n), .sweep_start(sweep_start), .sweep_busy(sweep_busy),
        .sweep_drop(sweep_drop), .coef_valid(coef_valid), .coef_idx(coef_idx),
        .coef_data(coef_data), .coef_last(coef_last), .host_req(host_req),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .cmem_cen(cmem_cen), .cmem_wen(cmem_wen), .cmem_a(cmem_a), .cmem_d(cmem_d),
        .cmem_q(cmem_q)
    );

    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < NTAP; k++) mem[k] <= DW'(k * 3);
        end else if (cmem_cen == 1'b0) begin
            if (cmem_wen == 1'b0) mem[cmem_a] <= cmem_d;
            else                  cmem_q <= mem[cmem_a];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (coef_valid === 1'b1) begin
            if (coef_q.size() == 0) chk("coef_unexpected", 32'(coef_idx), 32'hFFFF_FFFF);
            else begin
                coef_t e;
                e = coef_q.pop_front();
                chk("coef_idx",  32'(coef_idx),  32'(e.idx));
                chk("coef_data", 32'(coef_data), 32'(e.data));
                chk("coef_last", 32'(coef_last), 32'(e.last));
            end
        end else if (coef_last === 1'b1) begin
            chk("coef_last_no_valid", 32'(coef_last), 32'd0);
        end
        if (host_rvalid === 1'b1) begin
            if (host_q.size() == 0) chk("rvalid_unexpected", 32'(host_rdata), 32'hFFFF_FFFF);
            else chk("host_rdata", 32'(host_rdata), 32'(host_q.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sweep();
        for (int k = 0; k < NTAP; k++)
            coef_q.push_back('{idx: AW'(k), data: mem[k], last: (k == NTAP - 1)});
    endtask

    task automatic start_sweep();
        step();
        sweep_start = 1'b1;
        push_sweep();
        @(negedge clk);
        chk("sweep_accept_drop", 32'(sweep_drop), 32'd0);
    endtask

    // Cycles 1..66 after an accepted sweep; p1/p2 pulse sweep_start, hreq_at raises a host read.
    task automatic sweep_cycles(input int p1, input int p2, input int hreq_at, input logic [AW-1:0] haddr);
        for (int c = 1; c <= 66; c++) begin
            step();
            sweep_start = (c == p1) || (c == p2);
            if (c == hreq_at) begin
                host_req = 1'b1; host_we = 1'b0; host_addr = haddr;
            end
            @(negedge clk);
            chk("busy", 32'(sweep_busy), 32'(c <= 65));
            chk("cen",  32'(cmem_cen),   32'(c > 64));
            chk("addr", 32'(cmem_a),     (c <= 64) ? 32'(c - 1) : 32'd0);
            chk("drop", 32'(sweep_drop), 32'((c == p1) || (c == p2)));
            if (c <= 65) chk("no_ack_in_sweep", 32'(host_ack), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; sweep_start = 1'b1; preload = 1'b1;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        step(); preload = 1'b0;
        step(); step();
        @(negedge clk);
        chk("rst_cen", 32'(cmem_cen), 32'd1);
        chk("rst_wen", 32'(cmem_wen), 32'd1);
        chk("rst_a", 32'(cmem_a), 32'd0);
        chk("rst_d", 32'(cmem_d), 32'd0);
        chk("rst_busy", 32'(sweep_busy), 32'd0);
        chk("rst_drop", 32'(sweep_drop), 32'd0);
        chk("rst_cvalid", 32'(coef_valid), 32'd0);
        chk("rst_cidx", 32'(coef_idx), 32'd0);
        chk("rst_clast", 32'(coef_last), 32'd0);
        chk("rst_ack", 32'(host_ack), 32'd0);
        chk("rst_rvalid", 32'(host_rvalid), 32'd0);
        chk("rst_rdata", 32'(host_rdata), 32'd0);
        step(); sweep_start = 1'b0;
        step(); rst_n = 1'b1;

        // Full sweep over preloaded k*3 table
        start_sweep();
        sweep_cycles(-1, -1, -1, '0);

        // Host write then read-back at address 5
        step(); host_req = 1'b1; host_we = 1'b1; host_addr = 6'd5; host_wdata = 16'hBEEF;
        @(negedge clk); chk("wr_ack_early", 32'(host_ack), 32'd0);
        step(); @(negedge clk);
        chk("wr_ack", 32'(host_ack), 32'd1);
        chk("wr_cen", 32'(cmem_cen), 32'd0);
        chk("wr_wen", 32'(cmem_wen), 32'd0);
        chk("wr_a", 32'(cmem_a), 32'd5);
        chk("wr_d", 32'(cmem_d), 32'hBEEF);
        step(); host_req = 1'b0;
        @(negedge clk); chk("wr_ack_pulse", 32'(host_ack), 32'd0);
        step(); host_req = 1'b1; host_we = 1'b0; host_addr = 6'd5; host_q.push_back(16'hBEEF);
        @(negedge clk); chk("mem5_written", 32'(mem[5]), 32'hBEEF);
        step(); @(negedge clk);
        chk("rd_cen", 32'(cmem_cen), 32'd0);
        chk("rd_wen", 32'(cmem_wen), 32'd1);
        chk("rd_a", 32'(cmem_a), 32'd5);
        chk("rd_ack_early", 32'(host_ack), 32'd0);
        step(); @(negedge clk);
        chk("rd_ack", 32'(host_ack), 32'd1);
        chk("rd_rvalid", 32'(host_rvalid), 32'd1);
        step(); host_req = 1'b0;
        @(negedge clk);
        chk("rvalid_pulse", 32'(host_rvalid), 32'd0);
        chk("rdata_hold", 32'(host_rdata), 32'hBEEF);
        step(); @(negedge clk); chk("rdata_hold2", 32'(host_rdata), 32'hBEEF);

        // sweep_start during SWEEP and DRAIN is dropped
        start_sweep();
        sweep_cycles(10, 65, -1, '0);

        // Host pending through a sweep wins the first IDLE cycle
        host_q.push_back(mem[7]);
        start_sweep();
        sweep_cycles(66, -1, 20, 6'd7);
        step(); sweep_start = 1'b0;
        @(negedge clk);
        chk("prio_rd_cen", 32'(cmem_cen), 32'd0);
        chk("prio_rd_a", 32'(cmem_a), 32'd7);
        chk("prio_busy", 32'(sweep_busy), 32'd0);
        step(); @(negedge clk); chk("prio_ack", 32'(host_ack), 32'd1);
        step(); host_req = 1'b0;

        // Simultaneous request with priority cleared: sweep first, host after
        step(); host_req = 1'b1; host_we = 1'b0; host_addr = 6'd9; host_q.push_back(mem[9]);
        sweep_start = 1'b1; push_sweep();
        @(negedge clk); chk("tie_drop", 32'(sweep_drop), 32'd0);
        sweep_cycles(-1, -1, -1, '0);
        begin
            bit got = 1'b0;
            for (int w = 0; w < 6 && !got; w++) begin
                step(); @(negedge clk);
                if (host_ack === 1'b1) got = 1'b1;
            end
            chk("late_host_ack", 32'(got), 32'd1);
        end
        step(); host_req = 1'b0;

        // Reset mid-sweep abandons it
        start_sweep();
        for (int c = 1; c <= 30; c++) begin
            step(); sweep_start = 1'b0;
            if (c == 30) rst_n = 1'b0;
            @(negedge clk);
        end
        step(); coef_q.delete();
        @(negedge clk);
        chk("rst_mid_cen", 32'(cmem_cen), 32'd1);
        chk("rst_mid_busy", 32'(sweep_busy), 32'd0);
        chk("rst_mid_cvalid", 32'(coef_valid), 32'd0);
        step(); rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step(); @(negedge clk);
            chk("post_rst_idle_cen", 32'(cmem_cen), 32'd1);
        end
        start_sweep();
        sweep_cycles(-1, -1, -1, '0);

        step(); step();
        chk("coef_q_empty", 32'(coef_q.size()), 32'd0);
        chk("host_q_empty", 32'(host_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
